// File: rtl/freq_pkg.sv
// Shared types and widths for the frequency-meter gate controller.
package freq_pkg;

  localparam int unsigned RANGE_W = 2;
  localparam int unsigned WIN_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_GATE  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_LATCH = 3'd4
  } state_e;

endpackage

// File: rtl/gate_timer.sv
// Loadable down-counter; expire_c flags the last counted cycle of a loaded interval.
module gate_timer #(
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  input  logic             dec_i,
  output logic             expire_c
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // load has priority over decrement; never underflow past zero
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_c = dec_i && (count_q == CNT_W'(1));

endmodule

// File: rtl/freq_gate_ctrl.sv
// Gate-timing controller: sequences CLEAR -> GATE -> HOLD -> LATCH windows for the counter bank.
module freq_gate_ctrl
  import freq_pkg::*;
#(
  parameter int unsigned CNT_W    = 24,
  parameter int unsigned GATE0    = 1,
  parameter int unsigned GATE1    = 10,
  parameter int unsigned GATE2    = 100,
  parameter int unsigned GATE3    = 1000,
  parameter int unsigned HOLD_CYC = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic [RANGE_W-1:0] range_sel,
  output logic               cnt_clr_n,
  output logic               cnt_en,
  output logic               latch_n,
  output logic               busy,
  output logic               done,
  output logic [WIN_W-1:0]   win_cnt
);

  state_e             state_q, state_d;
  logic [RANGE_W-1:0] range_q, range_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic               clr_n_q, clr_n_d;
  logic               en_q, en_d;
  logic               latch_n_q, latch_n_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               tmr_load;
  logic [CNT_W-1:0]   tmr_val;
  logic               tmr_dec;
  logic               tmr_expire;
  logic [CNT_W-1:0]   gate_len;

  // gate length for the window in progress, fixed by the range captured on entry to CLEAR
  always_comb begin
    case (range_q)
      2'd0:    gate_len = CNT_W'(GATE0);
      2'd1:    gate_len = CNT_W'(GATE1);
      2'd2:    gate_len = CNT_W'(GATE2);
      default: gate_len = CNT_W'(GATE3);
    endcase
  end

  // one timer serves both the gate interval and the hold interval
  assign tmr_dec = ((state_q == ST_GATE) || (state_q == ST_HOLD)) && !stop;

  gate_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (tmr_load),
    .value_i  (tmr_val),
    .dec_i    (tmr_dec),
    .expire_c (tmr_expire)
  );

  always_comb begin
    state_d  = state_q;
    range_d  = range_q;
    win_d    = win_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_CLEAR;
          range_d = range_sel;
        end
      end
      ST_CLEAR: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          state_d  = ST_GATE;
          tmr_load = 1'b1;
          tmr_val  = gate_len;
        end
      end
      ST_GATE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (tmr_expire) begin
          if (HOLD_CYC == 0) begin
            state_d = ST_LATCH;
          end else begin
            state_d  = ST_HOLD;
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(HOLD_CYC);
          end
        end
      end
      ST_HOLD: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (tmr_expire) begin
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        // latch strobe is already out, so a stop here still completes the window
        done_d = 1'b1;
        win_d  = win_q + WIN_W'(1);
        if (cont && !stop) begin
          state_d = ST_CLEAR;
          range_d = range_sel;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    clr_n_d   = (state_d == ST_GATE) || (state_d == ST_HOLD) || (state_d == ST_LATCH);
    en_d      = (state_d == ST_GATE);
    latch_n_d = (state_d != ST_LATCH);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      range_q   <= '0;
      win_q     <= '0;
      clr_n_q   <= 1'b0;
      en_q      <= 1'b0;
      latch_n_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      range_q   <= range_d;
      win_q     <= win_d;
      clr_n_q   <= clr_n_d;
      en_q      <= en_d;
      latch_n_q <= latch_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign cnt_clr_n = clr_n_q;
  assign cnt_en    = en_q;
  assign latch_n   = latch_n_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign win_cnt   = win_q;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Bench for freq_gate_ctrl: one build with a 1-cycle hold and one with no hold, both checked against a window-offset model.
module tb_freq_gate_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       cont = 1'b0;
  logic [1:0] range_sel = 2'd0;

  logic       a_clr_n, a_en, a_latch_n, a_busy, a_done;
  logic [7:0] a_win;
  logic       b_clr_n, b_en, b_latch_n, b_busy, b_done;
  logic [7:0] b_win;

  int checks = 0;
  int errors = 0;

  freq_gate_ctrl #(.HOLD_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cont(cont),
    .range_sel(range_sel), .cnt_clr_n(a_clr_n), .cnt_en(a_en),
    .latch_n(a_latch_n), .busy(a_busy), .done(a_done), .win_cnt(a_win)
  );

  freq_gate_ctrl #(.HOLD_CYC(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cont(cont),
    .range_sel(range_sel), .cnt_clr_n(b_clr_n), .cnt_en(b_en),
    .latch_n(b_latch_n), .busy(b_busy), .done(b_done), .win_cnt(b_win)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: k = cycles since the window's CLEAR edge (-1 when idle).
  // Window layout: k=0 clear, 1..G gate, G+1..G+H hold, G+H+1 latch.
  int hold_of[2] = '{1, 0};
  int k[2]       = '{-1, -1};
  int g[2]       = '{1, 1};
  int win_m[2]   = '{0, 0};
  bit dn_m[2]    = '{1'b0, 1'b0};

  function automatic int gate_of(input logic [1:0] r);
    case (r)
      2'd0:    return 1;
      2'd1:    return 10;
      2'd2:    return 100;
      default: return 1000;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        k[i] = -1; win_m[i] = 0; dn_m[i] = 1'b0;
      end else begin
        dn_m[i] = 1'b0;
        if (k[i] < 0) begin
          if (start && !stop) begin k[i] = 0; g[i] = gate_of(range_sel); end
        end else if (k[i] == g[i] + hold_of[i] + 1) begin
          dn_m[i]  = 1'b1;
          win_m[i] = (win_m[i] + 1) % 256;
          if (cont && !stop) begin k[i] = 0; g[i] = gate_of(range_sel); end
          else k[i] = -1;
        end else if (stop) begin
          k[i] = -1;
        end else begin
          k[i] = k[i] + 1;
        end
      end
    end
  end

  task automatic cmp_inst(input int i, input string p, input logic clr_n, input logic en,
                          input logic ln, input logic bs, input logic dn, input logic [7:0] w);
    chk({p, "_clr_n"},  32'(clr_n), 32'(k[i] >= 1));
    chk({p, "_en"},     32'(en),    32'((k[i] >= 1) && (k[i] <= g[i])));
    chk({p, "_latch_n"},32'(ln),    32'(k[i] != g[i] + hold_of[i] + 1));
    chk({p, "_busy"},   32'(bs),    32'(k[i] >= 0));
    chk({p, "_done"},   32'(dn),    32'(dn_m[i]));
    chk({p, "_win"},    32'(w),     32'(win_m[i]));
  endtask

  always @(negedge clk) begin
    cmp_inst(0, "m_h1", a_clr_n, a_en, a_latch_n, a_busy, a_done, a_win);
    cmp_inst(1, "m_h0", b_clr_n, b_en, b_latch_n, b_busy, b_done, b_win);
  end

  // Observation of the hold-1 build over n cycles, starting at the current negedge
  int q_runs[$];
  int q_done[$];
  int ob_en, ob_latch, ob_done, ob_clr;

  task automatic observe(input int n);
    int run;
    run = 0;
    q_runs.delete(); q_done.delete();
    ob_en = 0; ob_latch = 0; ob_done = 0; ob_clr = 0;
    for (int c = 0; c < n; c++) begin
      if (a_en) begin run++; ob_en++; end
      else if (run > 0) begin q_runs.push_back(run); run = 0; end
      if (!a_latch_n) ob_latch++;
      if (a_done) begin ob_done++; q_done.push_back(c); end
      if (a_busy && !a_clr_n) ob_clr++;
      @(negedge clk);
    end
  endtask

  initial begin
    int nd;
    repeat (2) @(negedge clk);
    chk("rst_clr_n", 32'(a_clr_n), 0);
    chk("rst_en", 32'(a_en), 0);
    chk("rst_latch_n", 32'(a_latch_n), 1);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_win", 32'(a_win), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single shot, G=1
    start = 1'b1; range_sel = 2'd0; cont = 1'b0;
    @(negedge clk);
    start = 1'b0;
    observe(8);
    chk("t2_clr_cycles", 32'(ob_clr), 1);
    chk("t2_en_cycles", 32'(ob_en), 1);
    chk("t2_latch_cycles", 32'(ob_latch), 1);
    chk("t2_done_cnt", 32'(ob_done), 1);
    chk("t2_done_at", 32'(q_done.size() > 0 ? q_done[0] : -1), 4);
    chk("t2_win", 32'(a_win), 1);
    chk("t2_idle", 32'(a_busy), 0);

    // continuous, G=10, then range 2 from the next window on
    start = 1'b1; range_sel = 2'd1; cont = 1'b1;
    @(negedge clk);
    start = 1'b0;
    observe(30);
    chk("t3_runs_n", 32'(q_runs.size()), 2);
    if (q_runs.size() == 2) begin
      chk("t3_run0", 32'(q_runs[0]), 10);
      chk("t3_run1", 32'(q_runs[1]), 10);
    end
    chk("t3_done_n", 32'(q_done.size()), 2);
    if (q_done.size() == 2) chk("t3_period", 32'(q_done[1] - q_done[0]), 13);
    range_sel = 2'd2;
    observe(130);
    chk("t3b_runs_n", 32'(q_runs.size()), 2);
    if (q_runs.size() == 2) chk("t3b_run_g100", 32'(q_runs[1]), 100);
    chk("t3b_done_n", 32'(q_done.size()), 2);
    if (q_done.size() == 2) chk("t3b_period", 32'(q_done[1] - q_done[0]), 103);
    stop = 1'b1; cont = 1'b0;
    @(negedge clk);
    stop = 1'b0;
    chk("t3_stopped", 32'(a_busy), 0);
    chk("t3_win", 32'(a_win), 5);

    // abort in gate cycle 5
    start = 1'b1; range_sel = 2'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("t4_in_gate", 32'(a_en), 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("t4_busy", 32'(a_busy), 0);
    chk("t4_en", 32'(a_en), 0);
    chk("t4_clr_n", 32'(a_clr_n), 0);
    observe(15);
    chk("t4_no_latch", 32'(ob_latch), 0);
    chk("t4_no_done", 32'(ob_done), 0);
    chk("t4_win", 32'(a_win), 5);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("t4_start_stop", 32'(a_busy), 0);
    @(negedge clk);
    chk("t4_still_idle", 32'(a_busy), 0);

    // zero-hold build: latch directly after gate; cont dropped during latch
    start = 1'b1; range_sel = 2'd1; cont = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("t5_last_en", 32'(b_en), 1);
    @(negedge clk);
    chk("t5_en_low", 32'(b_en), 0);
    chk("t5_latch_low", 32'(b_latch_n), 0);
    cont = 1'b0;
    @(negedge clk);
    chk("t5_done", 32'(b_done), 1);
    chk("t5_idle", 32'(b_busy), 0);
    repeat (3) @(negedge clk);
    chk("t5_h1_idle", 32'(a_busy), 0);
    chk("t5_h1_win", 32'(a_win), 6);

    // reset mid-gate
    start = 1'b1; range_sel = 2'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("t1_in_gate", 32'(a_en), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_en", 32'(a_en), 0);
    chk("t1_clr_n", 32'(a_clr_n), 0);
    chk("t1_latch_n", 32'(a_latch_n), 1);
    chk("t1_busy", 32'(a_busy), 0);
    chk("t1_win", 32'(a_win), 0);
    chk("t1_h0_en", 32'(b_en), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 256 continuous windows at G=1 (period 4)
    start = 1'b1; range_sel = 2'd0; cont = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    for (int c = 0; c < 1024; c++) begin
      if (a_done) nd++;
      if (c == 1020) chk("t6_win255", 32'(a_win), 255);
      @(negedge clk);
    end
    chk("t6_done_cnt", 32'(nd), 255);
    chk("t6_done", 32'(a_done), 1);
    chk("t6_wrap", 32'(a_win), 0);
    stop = 1'b1; cont = 1'b0;
    @(negedge clk);
    stop = 1'b0;
    chk("t6_stopped", 32'(a_busy), 0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
